// File: rtl/program_memory_loadable.sv
// Loadable instruction store for the 8-bit accumulator CPU.
// Fills itself with HALT after reset, then serves fetches or accepts a streamed program.
module program_memory_loadable #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD = 8'b000_1_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_fetch_data;
    logic                    r_fetch_valid;
    logic                    r_load_done;
    logic                    r_load_overflow;

    logic                    w_accept;
    logic                    w_we;
    logic                    w_ptr_end;
    logic [DATA_WIDTH-1:0]   w_wdata;

    assign w_accept  = (r_state == ST_LOAD) && load_valid;
    assign w_ptr_end = (r_ptr == '1);
    assign w_we      = !rst && ((r_state == ST_CLEAR) || w_accept);
    assign w_wdata   = (r_state == ST_CLEAR) ? FILL_WORD : load_data;

    // Storage has no reset of its own; the CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_CLEAR;
            r_ptr           <= '0;
            r_fetch_data    <= '0;
            r_fetch_valid   <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_load_done   <= 1'b0;
            unique case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (w_ptr_end) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fetch_en) begin
                        r_fetch_data  <= r_mem[fetch_addr];
                        r_fetch_valid <= 1'b1;
                    end
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (load_last || w_ptr_end) begin
                            r_state     <= ST_RUN;
                            r_load_done <= 1'b1;
                        end
                        // A full memory without an end marker is a truncated program.
                        if (!load_last && w_ptr_end) begin
                            r_load_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign fetch_data    = r_fetch_data;
    assign fetch_valid   = r_fetch_valid;
    assign load_done     = r_load_done;
    assign load_overflow = r_load_overflow;
    assign load_ready    = (r_state == ST_LOAD);
    assign busy          = (r_state != ST_RUN);

endmodule
